// File: rtl/rs_issue_scheduler.sv
// Reservation station for the ALU/branch unit: CDB wake-up, lowest-index
// ready select, registered issue onto the FU inputs, flush on mispredict.
module rs_issue_scheduler #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int OP_LOG  = 6,
  parameter int ROB_LOG = 4,
  parameter logic [OP_LOG-1:0] OP_NOP = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               jump_flag,
  input  logic               in_valid,
  input  logic [OP_LOG-1:0]  in_op,
  input  logic [31:0]        in_Vj,
  input  logic [31:0]        in_Vk,
  input  logic [ROB_LOG-1:0] in_Qj,
  input  logic [ROB_LOG-1:0] in_Qk,
  input  logic               in_Qj_busy,
  input  logic               in_Qk_busy,
  input  logic [31:0]        in_Imm,
  input  logic [ROB_LOG-1:0] in_DestRob,
  input  logic [31:0]        in_CurPC,
  output logic               full,
  input  logic               cdb0_en,
  input  logic [ROB_LOG-1:0] cdb0_rob,
  input  logic [31:0]        cdb0_val,
  input  logic               cdb1_en,
  input  logic [ROB_LOG-1:0] cdb1_rob,
  input  logic [31:0]        cdb1_val,
  output logic               RS_valid,
  output logic [OP_LOG-1:0]  RS_op,
  output logic [31:0]        RS_Vj,
  output logic [31:0]        RS_Vk,
  output logic [31:0]        RS_Imm,
  output logic [31:0]        RS_CurPC,
  output logic [ROB_LOG-1:0] RS_DestRob
);

  typedef struct packed {
    logic               busy;
    logic [OP_LOG-1:0]  op;
    logic [31:0]        vj;
    logic [ROB_LOG-1:0] qj;
    logic               qj_busy;
    logic [31:0]        vk;
    logic [ROB_LOG-1:0] qk;
    logic               qk_busy;
    logic [31:0]        imm;
    logic [ROB_LOG-1:0] dest;
    logic [31:0]        pc;
  } ent_t;

  ent_t ent_q [ENTRIES];
  ent_t ent_d [ENTRIES];

  logic               rs_valid_q, rs_valid_d;
  logic [OP_LOG-1:0]  rs_op_q, rs_op_d;
  logic [31:0]        rs_vj_q, rs_vj_d;
  logic [31:0]        rs_vk_q, rs_vk_d;
  logic [31:0]        rs_imm_q, rs_imm_d;
  logic [31:0]        rs_pc_q, rs_pc_d;
  logic [ROB_LOG-1:0] rs_dest_q, rs_dest_d;
  logic               full_q, full_d;

  logic             sel_found, free_found;
  logic [IDX_W-1:0] sel_idx, free_idx;
  logic [IDX_W:0]   cnt;

  // Returns {still_pending, value}; cdb0 has priority on a shared tag.
  function automatic logic [32:0] snoop(
    input logic               pend,
    input logic [ROB_LOG-1:0] tag,
    input logic [31:0]        val
  );
    logic [32:0] r;
    r = {pend, val};
    if (pend && cdb0_en && cdb0_rob == tag)
      r = {1'b0, cdb0_val};
    else if (pend && cdb1_en && cdb1_rob == tag)
      r = {1'b0, cdb1_val};
    return r;
  endfunction

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!ent_q[i].busy) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    ent_d      = ent_q;
    rs_valid_d = 1'b0;
    rs_op_d    = rs_op_q;
    rs_vj_d    = rs_vj_q;
    rs_vk_d    = rs_vk_q;
    rs_imm_d   = rs_imm_q;
    rs_pc_d    = rs_pc_q;
    rs_dest_d  = rs_dest_q;
    if (rdy && jump_flag) begin
      for (int i = 0; i < ENTRIES; i++)
        ent_d[i].busy = 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (ent_q[i].busy) begin
          {ent_d[i].qj_busy, ent_d[i].vj} =
            snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
          {ent_d[i].qk_busy, ent_d[i].vk} =
            snoop(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
        end
      end
      // Snapshot comes from the pre-wake-up state: no CDB bypass to the FU.
      if (sel_found) begin
        rs_valid_d          = 1'b1;
        rs_op_d             = ent_q[sel_idx].op;
        rs_vj_d             = ent_q[sel_idx].vj;
        rs_vk_d             = ent_q[sel_idx].vk;
        rs_imm_d            = ent_q[sel_idx].imm;
        rs_pc_d             = ent_q[sel_idx].pc;
        rs_dest_d           = ent_q[sel_idx].dest;
        ent_d[sel_idx].busy = 1'b0;
      end
      if (in_valid && free_found) begin
        ent_d[free_idx].busy = 1'b1;
        ent_d[free_idx].op   = in_op;
        ent_d[free_idx].qj   = in_Qj;
        ent_d[free_idx].qk   = in_Qk;
        ent_d[free_idx].imm  = in_Imm;
        ent_d[free_idx].dest = in_DestRob;
        ent_d[free_idx].pc   = in_CurPC;
        {ent_d[free_idx].qj_busy, ent_d[free_idx].vj} =
          snoop(in_Qj_busy, in_Qj, in_Vj);
        {ent_d[free_idx].qk_busy, ent_d[free_idx].vk} =
          snoop(in_Qk_busy, in_Qk, in_Vk);
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < ENTRIES; i++)
      cnt = cnt + {{IDX_W{1'b0}}, ent_d[i].busy};
    full_d = cnt >= (IDX_W + 1)'(ENTRIES - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        ent_q[i] <= '0;
      rs_valid_q <= 1'b0;
      rs_op_q    <= OP_NOP;
      rs_vj_q    <= '0;
      rs_vk_q    <= '0;
      rs_imm_q   <= '0;
      rs_pc_q    <= '0;
      rs_dest_q  <= '0;
      full_q     <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      rs_valid_q <= rs_valid_d;
      rs_op_q    <= rs_op_d;
      rs_vj_q    <= rs_vj_d;
      rs_vk_q    <= rs_vk_d;
      rs_imm_q   <= rs_imm_d;
      rs_pc_q    <= rs_pc_d;
      rs_dest_q  <= rs_dest_d;
      full_q     <= full_d;
    end
  end

  // Dispatching into a station with no free slot is a dispatcher bug.
  always @(posedge clk) begin
    if (!rst && rdy && !jump_flag && in_valid)
      assert (free_found);
  end

  assign full       = full_q;
  assign RS_valid   = rs_valid_q;
  assign RS_op      = rs_op_q;
  assign RS_Vj      = rs_vj_q;
  assign RS_Vk      = rs_vk_q;
  assign RS_Imm     = rs_imm_q;
  assign RS_CurPC   = rs_pc_q;
  assign RS_DestRob = rs_dest_q;

endmodule
